// File: rtl/vend_dispense_arb.sv
// rtl/vend_dispense_arb.sv - two-panel round-robin dispenser arbiter with credit check and change payout
//
// Purpose: grants one of two panel purchase requests at a time to the shared
// dispenser. It checks the captured credit against the drink price, then either
// runs the motor for DISP_CYCLES cycles and pays out change, or refunds the
// credit in full.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   reqN_vld/sel/credit    panel N request: valid, drink (0=A, 1=B), credit in half-units
//   reqN_rdy               panel N request accepted this cycle (combinational, IDLE only)
//   out1, out2             drink A / drink B motor on
//   chg_vld/amt/id         one-cycle change or refund payout, amount, target panel
//   rej                    one-cycle reject pulse for insufficient credit
//   busy                   transaction in progress
module vend_dispense_arb #(
  parameter int CREDIT_W    = 3,
  parameter int PRICE_A     = 3,
  parameter int PRICE_B     = 5,
  parameter int DISP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_vld,
  input  logic                req0_sel,
  input  logic [CREDIT_W-1:0] req0_credit,
  output logic                req0_rdy,
  input  logic                req1_vld,
  input  logic                req1_sel,
  input  logic [CREDIT_W-1:0] req1_credit,
  output logic                req1_rdy,
  output logic                out1,
  output logic                out2,
  output logic                chg_vld,
  output logic [CREDIT_W-1:0] chg_amt,
  output logic                chg_id,
  output logic                rej,
  output logic                busy
);

  localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES + 1) : 1;
  localparam logic [CREDIT_W-1:0] PA = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB = CREDIT_W'(PRICE_B);

  typedef enum logic [1:0] {IDLE, DISP, CHG, REFUND} state_t;

  state_t              state, state_nxt;
  logic                rr_last;
  logic                cap_id, cap_sel;
  logic [CREDIT_W-1:0] cap_credit;
  logic [CNT_W-1:0]    cnt;

  logic                grant0, grant1, accept, win_id, win_sel;
  logic [CREDIT_W-1:0] win_credit, win_price, cap_price, chg_diff;

  // On a tie the panel that did not win last time is granted; rr_last=1 after
  // reset so panel 0 takes the first tie.
  assign grant0     = (state == IDLE) && req0_vld && (!req1_vld || rr_last);
  assign grant1     = (state == IDLE) && req1_vld && (!req0_vld || !rr_last);
  assign accept     = grant0 || grant1;
  assign win_id     = grant1;
  assign win_sel    = grant1 ? req1_sel : req0_sel;
  assign win_credit = grant1 ? req1_credit : req0_credit;
  assign win_price  = win_sel ? PB : PA;
  assign cap_price  = cap_sel ? PB : PA;
  // Only reached after credit >= price was established, so no underflow.
  assign chg_diff   = cap_credit - cap_price;

  assign req0_rdy = grant0;
  assign req1_rdy = grant1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last    <= 1'b1;
      cap_id     <= 1'b0;
      cap_sel    <= 1'b0;
      cap_credit <= '0;
      cnt        <= '0;
    end else if (accept) begin
      rr_last    <= win_id;
      cap_id     <= win_id;
      cap_sel    <= win_sel;
      cap_credit <= win_credit;
      cnt        <= CNT_W'(DISP_CYCLES);
    end else if (state == DISP) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (win_credit >= win_price) ? DISP : REFUND;
      DISP:    if (cnt == CNT_W'(1)) state_nxt = CHG;
      CHG:     state_nxt = IDLE;
      REFUND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out1    = 1'b0;
    out2    = 1'b0;
    chg_vld = 1'b0;
    chg_amt = '0;
    chg_id  = 1'b0;
    rej     = 1'b0;
    busy    = (state != IDLE);
    case (state)
      DISP: begin
        out1 = !cap_sel;
        out2 = cap_sel;
      end
      CHG: begin
        chg_amt = chg_diff;
        chg_vld = (chg_diff != '0);
        chg_id  = cap_id;
      end
      REFUND: begin
        rej     = 1'b1;
        chg_amt = cap_credit;
        chg_vld = (cap_credit != '0);
        chg_id  = cap_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vend_dispense_arb.sv
// tb/tb_vend_dispense_arb.sv - self-checking bench for vend_dispense_arb
module tb_vend_dispense_arb;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_vld = 0, req0_sel = 0, req1_vld = 0, req1_sel = 0;
  logic [2:0] req0_credit = 0, req1_credit = 0;
  logic       req0_rdy, req1_rdy, out1, out2, chg_vld, chg_id, rej, busy;
  logic [2:0] chg_amt;

  // Second build with a one-cycle dispense.
  logic       rst2 = 1'b1;
  logic       b_vld0 = 0, b_sel0 = 0, b_vld1 = 0, b_sel1 = 0;
  logic [2:0] b_cr0 = 0, b_cr1 = 0;
  logic       b_rdy0, b_rdy1, b_o1, b_o2, b_cv, b_ci, b_rej, b_busy;
  logic [2:0] b_amt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_dispense_arb #(.CREDIT_W(3), .PRICE_A(3), .PRICE_B(5), .DISP_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_sel(req0_sel), .req0_credit(req0_credit), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_sel(req1_sel), .req1_credit(req1_credit), .req1_rdy(req1_rdy),
    .out1(out1), .out2(out2), .chg_vld(chg_vld), .chg_amt(chg_amt), .chg_id(chg_id),
    .rej(rej), .busy(busy)
  );

  vend_dispense_arb #(.CREDIT_W(3), .PRICE_A(3), .PRICE_B(5), .DISP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst2),
    .req0_vld(b_vld0), .req0_sel(b_sel0), .req0_credit(b_cr0), .req0_rdy(b_rdy0),
    .req1_vld(b_vld1), .req1_sel(b_sel1), .req1_credit(b_cr1), .req1_rdy(b_rdy1),
    .out1(b_o1), .out2(b_o2), .chg_vld(b_cv), .chg_amt(b_amt), .chg_id(b_ci),
    .rej(b_rej), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {rdy0, rdy1, out1, out2, chg_vld, chg_amt, chg_id (only when paying), rej, busy}
  function automatic logic [10:0] act_vec();
    return {req0_rdy, req1_rdy, out1, out2, chg_vld, chg_amt, chg_vld & chg_id, rej, busy};
  endfunction

  // Directed vectors: in = {rst, v0, s0, c0[3], v1, s1, c1[3]}
  typedef struct {
    logic [10:0] in;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[31];

  // Transaction-level reference model: each accepted request expands into a
  // timeline of expected per-cycle outputs; an empty timeline means IDLE.
  typedef struct packed {
    logic       o1, o2, cv;
    logic [2:0] ca;
    logic       ci, rj;
  } ent_t;
  ent_t plan[$];
  bit   m_rr = 1'b1;
  bit   p_vld[2];
  bit   p_sel[2];
  int   p_cr[2];
  int   last_grant;

  task automatic cyc(input bit do_rst, input string nm);
    logic [10:0] exp;
    bit g0, g1;
    int id, pr;
    ent_t e;
    @(negedge clk);
    rst = do_rst;
    req0_vld = p_vld[0]; req0_sel = p_sel[0]; req0_credit = 3'(p_cr[0]);
    req1_vld = p_vld[1]; req1_sel = p_sel[1]; req1_credit = 3'(p_cr[1]);
    #1;
    g0 = 0; g1 = 0;
    if (plan.size() == 0) begin
      g0 = p_vld[0] && (!p_vld[1] || m_rr);
      g1 = p_vld[1] && (!p_vld[0] || !m_rr);
      exp = {g0, g1, 9'b0};
    end else begin
      e = plan[0];
      exp = {2'b00, e.o1, e.o2, e.cv, e.ca, e.ci & e.cv, e.rj, 1'b1};
    end
    chk(nm, act_vec(), exp);
    last_grant = -1;
    if (do_rst) begin
      plan.delete();
      m_rr = 1'b1;
    end else if (plan.size() != 0) begin
      void'(plan.pop_front());
    end else if (g0 || g1) begin
      id = g1 ? 1 : 0;
      pr = p_sel[id] ? 5 : 3;
      if (p_cr[id] >= pr) begin
        for (int k = 0; k < D; k++) plan.push_back('{o1: !p_sel[id], o2: p_sel[id], default: 0});
        plan.push_back('{cv: (p_cr[id] != pr), ca: 3'(p_cr[id] - pr), ci: id[0], default: 0});
      end else begin
        plan.push_back('{rj: 1, cv: (p_cr[id] != 0), ca: 3'(p_cr[id]), ci: id[0], default: 0});
      end
      m_rr = id[0];
      p_vld[id] = 0;
      last_grant = id;
    end
  endtask

  int grants[$];

  initial begin
    tbl[0]  = '{11'b0_0_0_000_0_0_000, 11'b0_0_0_0_0_000_0_0_0};
    tbl[1]  = '{11'b0_1_0_100_0_0_000, 11'b1_0_0_0_0_000_0_0_0};
    for (int i = 2; i <= 5; i++) tbl[i] = '{11'b0, 11'b0_0_1_0_0_000_0_0_1};
    tbl[6]  = '{11'b0, 11'b0_0_0_0_1_001_0_0_1};
    tbl[7]  = '{11'b0_0_0_000_1_1_101, 11'b0_1_0_0_0_000_0_0_0};
    for (int i = 8; i <= 11; i++) tbl[i] = '{11'b0, 11'b0_0_0_1_0_000_0_0_1};
    tbl[12] = '{11'b0, 11'b0_0_0_0_0_000_0_0_1};
    tbl[13] = '{11'b0_1_1_011_0_0_000, 11'b1_0_0_0_0_000_0_0_0};
    tbl[14] = '{11'b0, 11'b0_0_0_0_1_011_0_1_1};
    tbl[15] = '{11'b0_1_0_011_0_0_000, 11'b1_0_0_0_0_000_0_0_0};
    tbl[16] = '{11'b0, 11'b0_0_1_0_0_000_0_0_1};
    tbl[17] = '{11'b1_1_0_111_1_0_110, 11'b0_0_1_0_0_000_0_0_1};
    tbl[18] = '{11'b0_1_0_111_1_0_110, 11'b1_0_0_0_0_000_0_0_0};
    for (int i = 19; i <= 22; i++) tbl[i] = '{11'b0_0_0_000_1_0_110, 11'b0_0_1_0_0_000_0_0_1};
    tbl[23] = '{11'b0_0_0_000_1_0_110, 11'b0_0_0_0_1_100_0_0_1};
    tbl[24] = '{11'b0_0_0_000_1_0_110, 11'b0_1_0_0_0_000_0_0_0};
    for (int i = 25; i <= 28; i++) tbl[i] = '{11'b0, 11'b0_0_1_0_0_000_0_0_1};
    tbl[29] = '{11'b0, 11'b0_0_0_0_1_011_1_0_1};
    tbl[30] = '{11'b0, 11'b0};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      {rst, req0_vld, req0_sel, req0_credit, req1_vld, req1_sel, req1_credit} = tbl[i].in;
      #1;
      chk($sformatf("tbl%0d", i), act_vec(), tbl[i].exp);
    end

    // Both panels requesting continuously from reset.
    p_vld[0] = 0; p_vld[1] = 0;
    cyc(1'b1, "cont_rst");
    for (int c = 0; c < 30; c++) begin
      if (!p_vld[0]) begin p_vld[0] = 1; p_sel[0] = 0; p_cr[0] = 3; end
      if (!p_vld[1]) begin p_vld[1] = 1; p_sel[1] = 1; p_cr[1] = 7; end
      cyc(1'b0, "cont");
      if (req0_rdy || req1_rdy) grants.push_back(req1_rdy ? 1 : 0);
      if (req0_rdy && req1_rdy) chk("rdy_both", 1, 0);
    end
    chk("cont_ngrants", (grants.size() >= 4), 1);
    if (grants.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("cont_grant%0d", k), grants[k], k % 2);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++)
        if (!p_vld[p] && ($urandom_range(0, 2) == 0)) begin
          p_vld[p] = 1;
          p_sel[p] = $urandom_range(0, 1);
          p_cr[p]  = $urandom_range(0, 7);
        end
      cyc(($urandom_range(0, 99) == 0), "rand");
    end
    p_vld[0] = 0; p_vld[1] = 0;
    cyc(1'b1, "rand_end");

    // One-cycle dispense build.
    @(negedge clk); rst2 = 1;
    @(negedge clk); rst2 = 0;
    #1 chk("d1_reset", {b_rdy0, b_o1, b_o2, b_cv, b_amt, b_rej, b_busy}, 0);
    @(negedge clk); b_vld0 = 1; b_sel0 = 0; b_cr0 = 0;
    #1 chk("d1_rdy0", b_rdy0, 1);
    @(negedge clk); b_vld0 = 0;
    #1 chk("d1_refund", {b_o1, b_o2, b_rej, b_cv, b_amt, b_busy}, 8'b00_1_0_000_1);
    @(negedge clk); b_vld0 = 1; b_cr0 = 3;
    #1 chk("d1_rdy1", {b_rdy0, b_busy}, 2'b10);
    @(negedge clk); b_vld0 = 0;
    #1 chk("d1_disp", {b_o1, b_o2, b_rej, b_busy}, 4'b1001);
    @(negedge clk);
    #1 chk("d1_chg", {b_o1, b_o2, b_cv, b_amt, b_rej, b_busy}, 8'b00_0_000_0_1);
    @(negedge clk);
    #1 chk("d1_idle", {b_o1, b_busy}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
